ram_write_arbiter: RTL and testbench
====================================

// Module: ram_write_arbiter
// PURPOSE
//   Shares the single write port of the display/game RAM among NREQ requesters
//   (switch controller, game logic, host loader, ...). Arbitrates round-robin,
//   registers the winning address/data and holds ram_we for WR_CYCLES clocks.
//   It then pulses a one-cycle ack back to the winner. Sits between the
//   requesters and the RAM's we/addr/data inputs.
// PARAMETERS
//   NREQ       2   number of requesters (>=2)
//   AW         10  RAM address width
//   DW         8   RAM data width
//   WR_CYCLES  1   clocks ram_we is held per write (>=1; 0 treated as 1)
// PORTS
//   clk        in   1        system clock, all state on rising edge
//   rst        in   1        asynchronous reset, active-high
//   req        in   NREQ     per-requester write request, level, held until ack
//   req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   req_data   in   NREQ*DW  packed data, requester i at [i*DW +: DW]
//   ack        out  NREQ     one-cycle pulse: requester i's write is complete
//   busy       out  1        high in WRITE and ACK states
//   grant_id   out  $clog2(NREQ)  index of requester currently/last served
//   ram_we     out  1        RAM write enable
//   ram_addr   out  AW       RAM write address
//   ram_data   out  DW       RAM write data
// BEHAVIOUR
//   - All outputs are registered. Reset (async, immediate) forces the following:
//     ram_we=0, ram_addr=0, ram_data=0, ack=0, busy=0, grant_id=0, rr_ptr=0,
//     cnt=0, state=IDLE.
//   - FSM states: IDLE, WRITE, ACK.
//   - IDLE, any req bit set: winner = first i with req[i]=1, scanning from
//     rr_ptr upward mod NREQ. At the next edge:
//     - latch req_addr/req_data of the winner into ram_addr/ram_data;
//     - set ram_we=1, grant_id=winner, cnt=WR_CYCLES-1, state=WRITE.
//   - IDLE, no req: ram_we=0; ram_addr/ram_data hold their last value.
//   - WRITE: ram_we=1; addr/data stable; changes on req_addr/req_data are ignored.
//     - cnt>0: decrement cnt.
//     - cnt==0: next edge sets ram_we=0, ack[grant_id]=1, state=ACK.
//   - ACK: ack is one-hot for exactly one cycle. Next edge sets ack=0,
//     rr_ptr=(grant_id+1) mod NREQ, state=IDLE.
//   - Latency: req high at edge E gives ram_we high for edges E+1 .. E+WR_CYCLES.
//     ack is high for the cycle after the last write cycle.
//   - Service interval is WR_CYCLES+2 clocks per write, so there is no
//     back-to-back write without an IDLE cycle.
//   - Requester contract: drop req, or present new addr/data, on the edge at
//     which it samples ack=1. A req still high in IDLE is a new request.
//   - Simultaneous requests: round-robin. A requester holding req continuously
//     cannot starve others; worst-case wait is (NREQ-1)*(WR_CYCLES+2) clocks.
//   - req dropped during WRITE: the write still completes and ack still pulses.
//   - Reset during WRITE: ram_we falls immediately and the write is aborted
//     (no ack). After release, pending reqs are re-arbitrated from requester 0.
//   - rr_ptr wraps NREQ-1 -> 0. No address range check is made; addresses pass
//     through unchanged.
// TESTING
//   1 rst=1 with random inputs -> ram_we=0, ram_addr=0, ram_data=0, ack=0,
//     busy=0, all within the reset cycle.
//   2 WR_CYCLES=1, req=01, req_addr0=562, req_data0=8'h03 -> one cycle
//     ram_we=1 / ram_addr=562 / ram_data=03, then ack=01 for one cycle.
//   3 req=11 held, requesters never drop req -> grants alternate 0,1,0,1.
//     ack alternates 01,10; each write is 3 clocks apart.
//   4 WR_CYCLES=3, req0 addr=100 data=AA; change req_addr0 to 200 mid-write
//     -> ram_we high 3 cycles, ram_addr stays 100, one ack.
//   5 rst pulsed during the 2nd WRITE cycle (WR_CYCLES=3) -> ram_we=0 at once,
//     no ack. After release with req0 still high, full write to the same
//     address, ack=01.
//   6 req0 dropped one cycle after grant -> write completes unchanged,
//     ack=01 pulses, FSM returns to IDLE with busy=0.

Source files
------------

// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter
//   Shares the single RAM write port among NREQ requesters. Round-robin
//   arbitration picks a winner in IDLE, its address/data are registered and
//   ram_we is held for WR_CYCLES clocks, then a one-cycle ack pulses back to
//   the winner before returning to IDLE.
// Ports
//   clk, rst   clock, asynchronous active-high reset
//   req        per-requester level request, held until ack
//   req_addr   packed addresses, requester i at [i*AW +: AW]
//   req_data   packed data, requester i at [i*DW +: DW]
//   ack        one-cycle completion pulse, one-hot
//   busy       high while in WRITE or ACK
//   grant_id   requester currently/last served
//   ram_we, ram_addr, ram_data   registered RAM write port
module ram_write_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 10,
    parameter int DW        = 8,
    parameter int WR_CYCLES = 1,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int WC       = (WR_CYCLES < 1) ? 1 : WR_CYCLES,
    localparam int CW       = (WC > 1) ? $clog2(WC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_data
);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  cnt;

    logic [IDW-1:0] win;
    logic [IDW-1:0] idx;
    logic           win_vld;
    wr_req_t        win_req;

    // Scan downward from the farthest slot so the last hit is the one
    // closest to rr_ptr (i.e. first upward from rr_ptr, mod NREQ).
    always_comb begin
        win     = '0;
        idx     = '0;
        win_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign win_req.addr = req_addr[win*AW +: AW];
    assign win_req.data = req_data[win*DW +: DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ram_we <= 1'b0;
                    ack    <= '0;
                    if (win_vld) begin
                        ram_addr <= win_req.addr;
                        ram_data <= win_req.data;
                        ram_we   <= 1'b1;
                        grant_id <= win;
                        cnt      <= CW'(WC - 1);
                        busy     <= 1'b1;
                        state    <= WRITE;
                    end
                end
                // addr/data stay frozen here; requester inputs are ignored
                WRITE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ram_we <= 1'b0;
                        ack    <= NREQ'(1) << grant_id;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    ack    <= '0;
                    busy   <= 1'b0;
                    rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_write_arbiter.sv
// tb_ram_write_arbiter
//   Two instances: u_dut1 (WR_CYCLES=1, index 0) and u_dut3 (WR_CYCLES=3,
//   index 1). Expected writes are queued as stimulus is driven; a negedge
//   monitor pops them on each ram_we rising edge and checks grant, address,
//   data, write length, ack and busy.
module tb_ram_write_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 10;
    localparam int DW   = 8;

    typedef struct packed {
        logic [0:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic                clk;
    logic                rst      [2];
    logic [NREQ-1:0]     req      [2];
    logic [NREQ*AW-1:0]  req_addr [2];
    logic [NREQ*DW-1:0]  req_data [2];
    logic [NREQ-1:0]     ack      [2];
    logic                busy     [2];
    logic [0:0]          gid      [2];
    logic                we       [2];
    logic [AW-1:0]       ra       [2];
    logic [DW-1:0]       rd       [2];

    ram_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WR_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst[0]), .req(req[0]), .req_addr(req_addr[0]),
        .req_data(req_data[0]), .ack(ack[0]), .busy(busy[0]), .grant_id(gid[0]),
        .ram_we(we[0]), .ram_addr(ra[0]), .ram_data(rd[0])
    );

    ram_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WR_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst[1]), .req(req[1]), .req_addr(req_addr[1]),
        .req_data(req_data[1]), .ack(ack[1]), .busy(busy[1]), .grant_id(gid[1]),
        .ram_we(we[1]), .ram_addr(ra[1]), .ram_data(rd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    wr_t q0[$];
    wr_t q1[$];
    wr_t cur     [2];
    bit  prev_we [2];
    bit  pend    [2];
    int  run     [2];
    int  ack_cnt [2];
    int  cyc = 0;
    int  last_rise = -1;
    int  deltas[$];

    task automatic push(input int d, input int id, input int a, input int dt);
        wr_t e;
        e.id   = 1'(id);
        e.addr = AW'(a);
        e.data = DW'(dt);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int d);
        int sz;
        if (rst[d]) begin
            prev_we[d] = 1'b0;
            pend[d]    = 1'b0;
            run[d]     = 0;
            return;
        end
        chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(we[d] | (|ack[d])));
        if (we[d]) begin
            if (!prev_we[d]) begin
                sz = (d == 0) ? q0.size() : q1.size();
                if (sz == 0) begin
                    chk($sformatf("unexp_we%0d", d), 1, 0);
                end else begin
                    cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
                end
                chk($sformatf("gid%0d", d), 32'(gid[d]), 32'(cur[d].id));
                if (d == 0) begin
                    if (last_rise >= 0) deltas.push_back(cyc - last_rise);
                    last_rise = cyc;
                end
                run[d] = 0;
            end
            run[d]++;
            chk($sformatf("addr%0d", d), 32'(ra[d]), 32'(cur[d].addr));
            chk($sformatf("data%0d", d), 32'(rd[d]), 32'(cur[d].data));
        end else if (prev_we[d]) begin
            chk($sformatf("we_len%0d", d), run[d], (d == 0) ? 1 : 3);
            pend[d] = 1'b1;
        end
        if (|ack[d]) begin
            chk($sformatf("ack_exp%0d", d), 32'(pend[d]), 1);
            chk($sformatf("ack_val%0d", d), 32'(ack[d]), 32'(1) << cur[d].id);
            chk($sformatf("ack_after_we%0d", d), 32'(prev_we[d]), 1);
            ack_cnt[d]++;
            pend[d] = 1'b0;
        end else if (pend[d]) begin
            chk($sformatf("ack_missing%0d", d), 0, 1);
            pend[d] = 1'b0;
        end
        prev_we[d] = we[d];
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0);
        mon(1);
    end

    task automatic drive(input int d, input int id, input int a, input int dt);
        req_addr[d][id*AW +: AW] = AW'(a);
        req_data[d][id*DW +: DW] = DW'(dt);
        req[d][id] = 1'b1;
    endtask

    // requester side: drop req on the edge following the sampled ack
    task automatic wait_ack(input int d, input int id, input int budget);
        bit got = 1'b0;
        for (int t = 0; t < budget && !got; t++) begin
            @(negedge clk);
            if (ack[d][id]) got = 1'b1;
        end
        if (!got) chk($sformatf("ack_timeout%0d_%0d", d, id), 0, 1);
        @(posedge clk);
        #1 req[d][id] = 1'b0;
    endtask

    task automatic wait_cnt(input int d, input int target, input int budget);
        for (int t = 0; t < budget && ack_cnt[d] < target; t++) begin
            @(negedge clk);
            #1;
        end
        chk($sformatf("ack_count%0d", d), ack_cnt[d], target);
    endtask

    initial begin
        int base;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req[d] = '0; req_addr[d] = '0; req_data[d] = '0;
            prev_we[d] = 1'b0; pend[d] = 1'b0; run[d] = 0; ack_cnt[d] = 0;
        end
        // 1: reset with random inputs, outputs cleared before any clock edge
        #1;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            req[d] = NREQ'($urandom);
            req_addr[d] = (NREQ*AW)'({$urandom, $urandom});
            req_data[d] = (NREQ*DW)'($urandom);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_we",   32'(we[d]),   0);
            chk("rst_addr", 32'(ra[d]),   0);
            chk("rst_data", 32'(rd[d]),   0);
            chk("rst_ack",  32'(ack[d]),  0);
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_gid",  32'(gid[d]),  0);
        end
        @(posedge clk);
        #1 for (int d = 0; d < 2; d++) req[d] = '0;
        @(posedge clk);
        #3 for (int d = 0; d < 2; d++) rst[d] = 1'b0;

        // 2: single write, WR_CYCLES=1
        @(posedge clk); #1;
        push(0, 0, 562, 8'h03);
        drive(0, 0, 562, 8'h03);
        wait_ack(0, 0, 20);

        // 3: both held; requester 0 was served last so 1 goes first
        repeat (2) @(posedge clk);
        #1;
        deltas.delete();
        last_rise = -1;
        base = ack_cnt[0];
        push(0, 1, 10'h3FF, 8'hEE);
        push(0, 0, 10'h011, 8'h21);
        push(0, 1, 10'h3FF, 8'hEE);
        push(0, 0, 10'h011, 8'h21);
        drive(0, 0, 10'h011, 8'h21);
        drive(0, 1, 10'h3FF, 8'hEE);
        wait_cnt(0, base + 4, 60);
        @(posedge clk);
        #1 req[0] = '0;
        chk("rr_spacing_n", deltas.size(), 3);
        foreach (deltas[i]) chk("rr_spacing", deltas[i], 3);

        // 6: req dropped one cycle after grant
        repeat (2) @(posedge clk);
        #1;
        base = ack_cnt[0];
        push(0, 0, 10'h155, 8'h5C);
        drive(0, 0, 10'h155, 8'h5C);
        @(posedge clk);
        #1 req[0][0] = 1'b0;
        wait_cnt(0, base + 1, 20);
        @(posedge clk); #1;
        chk("drop_busy", 32'(busy[0]), 0);
        chk("drop_we",   32'(we[0]),   0);

        // 4: WR_CYCLES=3, inputs change mid-write
        @(posedge clk); #1;
        push(1, 0, 100, 8'hAA);
        drive(1, 0, 100, 8'hAA);
        @(posedge clk);
        @(posedge clk);
        #1 req_addr[1][0 +: AW] = AW'(200);
        req_data[1][0 +: DW] = 8'h55;
        wait_ack(1, 0, 20);

        // 5: reset during 2nd write cycle aborts; retry restarts from requester 0
        repeat (2) @(posedge clk);
        #1;
        push(1, 0, 300, 8'h5A);
        drive(1, 0, 300, 8'h5A);
        @(posedge clk);
        @(posedge clk);
        #2 rst[1] = 1'b1;
        #1;
        chk("abort_we",   32'(we[1]),   0);
        chk("abort_ack",  32'(ack[1]),  0);
        chk("abort_busy", 32'(busy[1]), 0);
        chk("abort_addr", 32'(ra[1]),   0);
        // rr_ptr before reset pointed at 1; after reset requester 0 must win
        push(1, 0, 300, 8'h5A);
        push(1, 1, 10'h2C3, 8'h77);
        drive(1, 1, 10'h2C3, 8'h77);
        @(posedge clk);
        #3 rst[1] = 1'b0;
        wait_ack(1, 0, 30);
        wait_ack(1, 1, 30);

        repeat (4) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("ack_total1", ack_cnt[1], 3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
